// File: rtl/bus_drv_pkg.sv
// bus_drv_pkg: shared state encoding, default sizes and clog2 helper for the bus drive sequencer
package bus_drv_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_NSRC = 4;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first valid request at or after ptr
module rr_arbiter
  import bus_drv_pkg::*;
#(
  parameter int NSRC = DEF_NSRC,
  parameter int IW = clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   win,
  output logic            any
);
  // scan from the farthest offset down so the nearest valid index overwrites last
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[IW'((int'(ptr) + i) % NSRC)]) begin
        win = IW'((int'(ptr) + i) % NSRC);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_drive_sequencer.sv
// bus_drive_sequencer: round-robin owner of a tri-state driver array with turnaround gaps; BUS_DRV_TIMEOUT_EN adds a stall timeout
module bus_drive_sequencer
  import bus_drv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSRC = DEF_NSRC,
  parameter int MAX_BURST = 8,
  parameter int TURN_CYCLES = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        req_valid,
  input  logic [NSRC*WIDTH-1:0]  req_data,
  input  logic [NSRC-1:0]        req_last,
  output logic [NSRC-1:0]        req_ready,
  output logic [WIDTH-1:0]       drv_data,
  output logic                   drv_en_n,
  output logic [clog2(NSRC)-1:0] owner,
  output logic                   busy,
  output logic                   err_timeout
);
  localparam int IW = clog2(NSRC);
  localparam int BW = clog2(MAX_BURST + 1);
  localparam int TW = clog2(TURN_CYCLES + 1);

  if (NSRC < 2 || MAX_BURST < 1 || TURN_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("bus_drive_sequencer: illegal parameter");
  end

  state_t          state;
  logic [IW-1:0]   rr_ptr, win;
  logic            any;
  logic [BW-1:0]   beat_cnt;
  logic [TW-1:0]   turn_cnt;
  logic            accept;

  rr_arbiter #(.NSRC(NSRC), .IW(IW)) u_arb (.req(req_valid), .ptr(rr_ptr), .win(win), .any(any));

  assign accept = (state == DRIVE) && req_valid[owner];
  assign busy = (state != IDLE);

  // only the owner sees ready, and only while it holds the bus
  always_comb req_ready = (state == DRIVE) ? (NSRC'(1) << owner) : '0;

`ifdef BUS_DRV_TIMEOUT_EN
  localparam int SW = clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_cnt;
  // consecutive stall cycles of the owner; forces the tenure to end at TIMEOUT
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= (state == DRIVE) && !accept && (stall_cnt == SW'(TIMEOUT - 1));
      stall_cnt <= (state != DRIVE || accept || stall_cnt == SW'(TIMEOUT - 1)) ? '0 : stall_cnt + 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  // ownership FSM with registered driver outputs; turn_cnt==0 marks the first TURN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      drv_en_n <= 1'b1;
      drv_data <= '0;
      owner <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          owner <= win;
          rr_ptr <= (win == IW'(NSRC - 1)) ? '0 : win + 1'b1;
          beat_cnt <= '0;
          state <= DRIVE;
        end
        DRIVE: begin
          if (accept) begin
            drv_data <= req_data[owner*WIDTH +: WIDTH];
            drv_en_n <= 1'b0;
            beat_cnt <= beat_cnt + 1'b1;
            if (req_last[owner] || beat_cnt == BW'(MAX_BURST - 1)) state <= TURN;
          end
`ifdef BUS_DRV_TIMEOUT_EN
          if (!accept && stall_cnt == SW'(TIMEOUT - 1)) state <= TURN;
`endif
        end
        TURN: if (turn_cnt == '0) begin
          drv_en_n <= 1'b1;
          turn_cnt <= TW'(TURN_CYCLES);
        end else begin
          turn_cnt <= turn_cnt - 1'b1;
          if (turn_cnt == TW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
